// File: rtl/gps_frame_ctrl_pkg.sv
// Shared definitions for the GPS sentence framer: FSM states, byte constants, header table.
// Latency: n/a (package only).
// Backpressure: n/a.
package gps_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } gps_state_t;

  localparam logic [7:0] CH_DOLLAR   = 8'h24;
  localparam logic [7:0] CH_STAR     = 8'h2A;
  localparam int         HDR_LEN     = 5;
  localparam int         MAX_LEN_DEF = 40;

  // Byte expected at each position of the "GPRMC" sentence identifier.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = 8'h47; // G
      3'd1:    b = 8'h50; // P
      3'd2:    b = 8'h52; // R
      3'd3:    b = 8'h4D; // M
      3'd4:    b = 8'h43; // C
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gps_frame_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, favoured-requester pointer is registered.
// Latency: 0 cycles request to grant.
// Backpressure: none; the pointer only moves on a contended grant, so a lone requester never loses priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr;

  // Pick the requester; on contention the one named by rr_ptr wins.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After a contended grant, hand priority to the loser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (en && (req == 2'b11)) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/gps_frame_ctrl.sv
// Parses "$GPRMC" sentences from the UART byte stream into the sentence RAM and arbitrates RAM reads between two consumers.
// Latency: RAM write same cycle as rx_valid; read data one cycle after grant.
// Backpressure: none on rx (bytes arriving while a frame is held are dropped); readers are served only while a frame is held.
module gps_frame_ctrl
  import gps_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = MAX_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  input  logic [1:0]            rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [1:0]            rd_gnt,
  output logic [1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frame_ready,
  output logic [ADDR_WIDTH-1:0] frame_len,
  input  logic                  frame_ack,
  output logic                  overflow_err
);

  // One extra bit so the count can reach MAX_LEN even when it equals the RAM depth.
  localparam int              CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_LEN);

  gps_state_t      state;
  logic [CW-1:0]   wr_cnt;
  logic [2:0]      hdr_idx;
  logic [1:0]      gnt;
  logic [1:0]      rd_valid_q;
  logic            is_dollar;
  logic            is_star;
  logic            wr_fire;

  assign is_dollar = (rx_data == CH_DOLLAR);
  assign is_star   = (rx_data == CH_STAR);

  // Payload bytes go straight to the RAM in the cycle they arrive; only CAPTURE may write.
  assign wr_fire    = (state == CAPTURE) && rx_valid && !is_dollar && !is_star && (wr_cnt < MAX_CNT);
  assign ram_we     = wr_fire;
  assign ram_addr_a = wr_fire ? wr_cnt[ADDR_WIDTH-1:0] : '0;
  assign ram_din_a  = wr_fire ? DATA_WIDTH'(rx_data) : '0;

  assign frame_ready = (state == DONE);

  // Sentence parser: hunt for '$', match the identifier, capture payload until '*'.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      hdr_idx      <= '0;
      frame_len    <= '0;
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && is_dollar) begin
            state   <= HDR;
            hdr_idx <= '0;
          end
        end
        HDR: begin
          if (rx_valid) begin
            if (rx_data == hdr_byte(hdr_idx)) begin
              if (hdr_idx == 3'(HDR_LEN - 1)) begin
                state   <= CAPTURE;
                wr_cnt  <= '0;
                hdr_idx <= '0;
              end else begin
                hdr_idx <= hdr_idx + 3'd1;
              end
            end else if (is_dollar) begin
              hdr_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        CAPTURE: begin
          if (rx_valid) begin
            if (is_star) begin
              frame_len <= wr_cnt[ADDR_WIDTH-1:0];
              state     <= DONE;
            end else if (is_dollar) begin
              state   <= HDR;
              hdr_idx <= '0;
            end else if (wr_cnt == MAX_CNT) begin
              overflow_err <= 1'b1;
              state        <= IDLE;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (frame_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readers may only touch the RAM while a complete frame is held.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == DONE),
    .req   (rd_req),
    .gnt   (gnt)
  );

  assign rd_gnt     = gnt;
  assign ram_addr_b = gnt[0] ? rd_addr0 : (gnt[1] ? rd_addr1 : '0);

  // The RAM registers the port-B address, so data returns one cycle after the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 2'b00;
    end else begin
      rd_valid_q <= gnt;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = (|rd_valid_q) ? ram_dout_b : '0;

endmodule

// File: tb/tb_gps_frame_ctrl.sv
// Scoreboard bench for gps_frame_ctrl with a behavioural RAM and sentence-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gps_frame_ctrl;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int ML = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;
  logic [1:0]    rd_req;
  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic [1:0]    rd_gnt;
  logic [1:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          frame_ready;
  logic [AW-1:0] frame_len;
  logic          frame_ack;
  logic          overflow_err;

  always #5 clk = ~clk;

  gps_frame_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_we(ram_we), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_len(frame_len), .frame_ack(frame_ack),
    .overflow_err(overflow_err)
  );

  // Dual-port RAM: synchronous write on A, registered read address on B.
  logic [7:0]    ram [64];
  logic [AW-1:0] addr_b_q;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr_a] <= ram_din_a;
    addr_b_q <= ram_addr_b;
  end
  assign ram_dout_b = ram[addr_b_q];

  // Reference state: expected writes/reads, the payload as written, overflow count, arbiter favourite.
  int          total = 0;
  int          bad   = 0;
  logic [13:0] exp_wq [$];
  logic [9:0]  exp_rq [$];
  logic [7:0]  model_mem [64];
  logic [7:0]  pay [64];
  int          exp_ovf = 0;
  int          ovf_seen = 0;
  bit          fav = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes the RAM or returns read data.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ram_we) begin
        total++;
        if (exp_wq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%0d data=%h expected none", ram_addr_a, ram_din_a);
        end else begin
          logic [13:0] e;
          e = exp_wq.pop_front();
          if ({ram_addr_a, ram_din_a} !== e) begin
            bad++;
            $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                     ram_addr_a, ram_din_a, e[13:8], e[7:0]);
          end
        end
      end
      if (rd_valid != 2'b00) begin
        total++;
        if (exp_rq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: valid=%b data=%h expected none", rd_valid, rd_data);
        end else begin
          logic [9:0] r;
          r = exp_rq.pop_front();
          if ({rd_valid, rd_data} !== r) begin
            bad++;
            $display("FAIL read: got valid=%b data=%h expected valid=%b data=%h",
                     rd_valid, rd_data, r[9:8], r[7:0]);
          end
        end
      end else begin
        check("rd_data_idle", 32'(rd_data), 32'h0);
      end
      if (overflow_err) ovf_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic set_pay(input string s);
    for (int i = 0; i < s.len(); i++) pay[i] = s[i];
  endtask

  task automatic rand_pay(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(32, 126));
      if (b == 8'h24 || b == 8'h2A) b = 8'h41;
      pay[i] = b;
    end
  endtask

  // "$GPRMC" + n payload bytes (+ '*'). Payload byte i lands at address i unless a frame is already held.
  task automatic send_rmc(input int n, input bit term, input bit expect_wr, input int maxgap);
    send_str("$GPRMC");
    for (int i = 0; i < n; i++) begin
      if (expect_wr && i < ML) begin
        exp_wq.push_back({6'(i), pay[i]});
        model_mem[i] = pay[i];
      end
      if (expect_wr && i == ML) exp_ovf++;
      send_byte(pay[i]);
      gap($urandom_range(0, maxgap));
    end
    if (term) send_byte(8'h2A);
  endtask

  // One read-request cycle; a contended pair is granted to the favourite, which then swaps.
  task automatic read_cycle(input logic [1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input bit ack);
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    rd_req = req; rd_addr0 = a0; rd_addr1 = a1; frame_ack = ack;
    if (req == 2'b11) begin
      eg  = fav ? 2'b10 : 2'b01;
      fav = ~fav;
    end else begin
      eg = req;
    end
    ea = eg[0] ? a0 : a1;
    @(negedge clk);
    check("rd_gnt", 32'(rd_gnt), 32'(eg));
    if (eg != 2'b00) begin
      check("ram_addr_b", 32'(ram_addr_b), 32'(ea));
      exp_rq.push_back({eg, model_mem[ea]});
    end
    @(posedge clk); #1;
    rd_req = 2'b00; frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rd_req = 2'b00; rd_addr0 = '0; rd_addr1 = '0; frame_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fav = 1'b0;
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr_a", 32'(ram_addr_a), 0);
    check("rst_ram_addr_b", 32'(ram_addr_b), 0);
    check("rst_rd_gnt", 32'(rd_gnt), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_frame_len", 32'(frame_len), 0);
    check("rst_overflow", 32'(overflow_err), 0);
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    @(negedge clk);
    check("ready_before_ack_edge", 32'(frame_ready), 1);
    @(posedge clk); #1;
    frame_ack = 1'b0;
    check("ready_after_ack", 32'(frame_ready), 0);
  endtask

  initial begin
    do_reset();

    // Basic frame.
    set_pay(",1234");
    send_rmc(5, 1'b1, 1'b1, 0);
    check("t1_ready", 32'(frame_ready), 1);
    check("t1_len", 32'(frame_len), 5);

    // Contended reads alternate 01,10,01,10.
    for (int i = 0; i < 4; i++) read_cycle(2'b11, 6'd0, 6'd1, 1'b0);
    gap(2);

    // A sentence arriving while a frame is held is ignored.
    set_pay(",Z");
    send_rmc(2, 1'b1, 1'b0, 0);
    check("t4_len", 32'(frame_len), 5);
    check("t4_ready", 32'(frame_ready), 1);
    ack_frame();

    // Wrong identifier produces no writes; following RMC does.
    send_str("$GPGGA,1*");
    set_pay(",A");
    send_rmc(2, 1'b1, 1'b1, 0);
    check("t5_len", 32'(frame_len), 2);
    read_cycle(2'b11, 6'd0, 6'd1, 1'b0);
    read_cycle(2'b11, 6'd0, 6'd1, 1'b0);
    // Grant in the same cycle as ack is still served.
    read_cycle(2'b01, 6'd1, 6'd0, 1'b1);
    check("t5_ready_after_ack", 32'(frame_ready), 0);
    gap(2);

    // Overflow: 41 payload bytes, no terminator.
    rand_pay(41);
    send_rmc(41, 1'b0, 1'b1, 0);
    gap(3);
    check("t6_ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));
    check("t6_ready", 32'(frame_ready), 0);

    // Reset in the middle of a capture.
    set_pay(",AB");
    send_rmc(3, 1'b0, 1'b1, 0);
    do_reset();
    set_pay(",XY");
    send_rmc(3, 1'b1, 1'b1, 0);
    check("t7_ready", 32'(frame_ready), 1);
    check("t7_len", 32'(frame_len), 3);
    ack_frame();

    // Randomized sentences with noise, restarts and random readers.
    for (int it = 0; it < 25; it++) begin
      int n;
      int kind;
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j;
        j = 8'($urandom_range(0, 255));
        if (j == 8'h24) j = 8'h25;
        send_byte(j);
      end
      kind = $urandom_range(0, 3);
      if (kind == 1) send_str("$GPX");
      else if (kind == 2) send_str("$GP");
      else if (kind == 3) begin
        int k;
        k = $urandom_range(0, 5);
        rand_pay(k);
        send_rmc(k, 1'b0, 1'b1, 1);
      end
      n = $urandom_range(0, ML);
      rand_pay(n);
      send_rmc(n, 1'b1, 1'b1, 2);
      check("rnd_ready", 32'(frame_ready), 1);
      check("rnd_len", 32'(frame_len), 32'(n));
      if (n > 0) begin
        repeat ($urandom_range(1, 8))
          read_cycle(2'($urandom_range(0, 3)), 6'($urandom_range(0, n - 1)),
                     6'($urandom_range(0, n - 1)), 1'b0);
        read_cycle(2'($urandom_range(0, 3)), 6'($urandom_range(0, n - 1)),
                   6'($urandom_range(0, n - 1)), 1'b1);
        check("rnd_ready_after_ack", 32'(frame_ready), 0);
      end else begin
        ack_frame();
      end
    end

    gap(4);
    check("writes_drained", 32'(exp_wq.size()), 0);
    check("reads_drained", 32'(exp_rq.size()), 0);
    check("ovf_total", 32'(ovf_seen), 32'(exp_ovf));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gps_frame_ctrl.md
Name: gps_frame_ctrl

Overview:
- Sequences the dual-port GPS sentence RAM (ADDR_WIDTH=6, DATA_WIDTH=8, synchronous write on port A, registered read address on both ports).
- Parses the UART byte stream for "$GPRMC" sentences and writes each payload into the RAM through port A.
- Signals when a complete frame is held.
- Round-robin arbitrates read port B between two consumers: display formatter and telemetry transmitter.
- Sits between the UART receiver and the RAM; the RAM's port-A read output is unused.

Parameters:
- ADDR_WIDTH, 6, RAM address width.
- DATA_WIDTH, 8, byte width.
- MAX_LEN, 40, payload byte limit; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- rx_data  in  8  received UART byte.
- ram_we  out  1  RAM port-A write enable.
- ram_addr_a  out  ADDR_WIDTH  RAM port-A address.
- ram_din_a  out  DATA_WIDTH  RAM port-A write data.
- ram_addr_b  out  ADDR_WIDTH  RAM port-B address.
- ram_dout_b  in  DATA_WIDTH  RAM port-B read data.
- rd_req  in  2  read request, bit i = consumer i.
- rd_addr0  in  ADDR_WIDTH  consumer 0 read address.
- rd_addr1  in  ADDR_WIDTH  consumer 1 read address.
- rd_gnt  out  2  one-hot grant, same cycle as request.
- rd_valid  out  2  one-hot; rd_data valid for consumer i.
- rd_data  out  DATA_WIDTH  read data.
- frame_ready  out  1  complete frame held in RAM.
- frame_len  out  ADDR_WIDTH  payload length of held frame.
- frame_ack  in  1  consumer releases frame.
- overflow_err  out  1  one-cycle pulse on payload overflow.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, wr_cnt=0, hdr_idx=0, frame_len=0, rr_ptr=0 (consumer 0 favoured).
  - All outputs 0 next cycle.
  - RAM contents are not cleared.
  - Reset mid-capture discards the partial frame; no frame_ready.
- Header constant "GPRMC" is matched byte by byte via hdr_idx 0..4. Byte values: '$'=0x24, '*'=0x2A.
- FSM (all transitions on rx_valid bytes only):
  - IDLE: '$' -> HDR with hdr_idx=0; any other byte is ignored.
  - HDR:
    - byte == header[hdr_idx]: hdr_idx++; after the 5th match -> CAPTURE with wr_cnt=0.
    - '$': restart HDR with hdr_idx=0.
    - other mismatch: -> IDLE.
  - CAPTURE:
    - '*': frame_len<=wr_cnt, -> DONE. The '*' byte is not written.
    - '$': abandon the partial frame, -> HDR.
    - any other byte: ram_we=1, ram_addr_a=wr_cnt, ram_din_a=rx_data (combinational, same cycle as rx_valid); wr_cnt++.
    - Non-terminator byte arriving with wr_cnt==MAX_LEN: not written; overflow_err pulses 1 cycle; -> IDLE.
    - The leading ',' after the header is payload byte 0.
  - DONE:
    - frame_ready=1; all rx bytes ignored, including '$'.
    - frame_ack -> IDLE; frame_ready drops the next cycle.
- ram_we is only ever 1 in CAPTURE, so readers never see a torn frame.
- Arbiter, active only in DONE; rd_gnt=0 in all other states:
  - Grant is combinational. With both requesting, grant consumer rr_ptr, then rr_ptr<=~winner. A single requester is granted immediately.
  - ram_addr_b = granted consumer's address; 0 when idle.
  - Latency is 1: rd_valid[i] is asserted the cycle after rd_gnt[i], with rd_data = ram_dout_b. Sustained 1 read/cycle.
  - Addresses ≥ frame_len are still served; data is unspecified.
  - frame_ack in the same cycle as a grant: the grant is honoured and rd_valid follows next cycle although the state is IDLE.
  - rd_valid and rd_data are 0 when no read is pending.
- Zero-length frame ("$GPRMC*") is legal: frame_len=0, frame_ready=1.

Decomposition:
- Shared package gps_pkg holds:
  - state encoding: IDLE, HDR, CAPTURE, DONE;
  - byte constants: '$'=0x24, '*'=0x2A, the "GPRMC" header bytes;
  - MAX_LEN default.
- One sub-module is natural: rr_arb2 (2-way round-robin arbiter, combinational grant, registered pointer).

Test Plan:
- Stream "$GPRMC,1234*" -> 5 writes at addr 0..4 with bytes ",1234", frame_ready=1, frame_len=5; no write for '*'.
- "$GPGGA,1*" then "$GPRMC,A*" -> no writes for GGA; RMC gives frame_len=2 and addr0=',', addr1='A'.
- 41 payload bytes after the header without '*' -> 40 writes, overflow_err single pulse at byte 41, state IDLE, frame_ready=0.
- In DONE, rd_req=2'b11 held 4 cycles with rd_addr0=0 and rd_addr1=1 -> grants 01,10,01,10; rd_valid follows 1 cycle later with data ',' and '1' alternating.
- rst_n=0 mid-CAPTURE after 3 bytes, then full "$GPRMC,XY*" -> outputs 0 after reset; new frame_len=3.
- In DONE, send "$GPRMC,Z*" without frame_ack -> no ram_we, frame_len unchanged; frame_ack then deasserts frame_ready next cycle.
